// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : simon_pkg
//  Description : Shared SIMON32/64 definitions: round-constant sequence z0,
//                rotate helpers, round function f(), forward key step,
//                controller state encoding and MIXED_SIZE legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package simon_pkg;

    // z0 sequence, string order: bit 61 holds z0[0], bit 0 holds z0[61]
    localparam logic [61:0] Z0     = 62'b11111010001001010110000111001101111101000100101011000011100110;
    // ~3, folds the "~k ^ 3" of the key schedule into one constant
    localparam logic [15:0] C_MASK = 16'hFFFC;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPAND  = 2'd1,
        DECRYPT = 2'd2
    } state_t;

    function automatic logic [15:0] rol16(input logic [15:0] v, input logic [3:0] r);
        logic [31:0] w;
        w = {v, v} << r;
        return w[31:16];
    endfunction

    function automatic logic [15:0] ror16(input logic [15:0] v, input logic [3:0] r);
        logic [31:0] w;
        w = {v, v} >> r;
        return w[15:0];
    endfunction

    function automatic logic [15:0] simon_f(input logic [15:0] x);
        return (rol16(x, 4'd1) & rol16(x, 4'd8)) ^ rol16(x, 4'd2);
    endfunction

    function automatic logic z0_bit(input logic [4:0] idx);
        logic [5:0] pos;
        pos = 6'd61 - {1'b0, idx};
        return Z0[pos];
    endfunction

    // k_base ^ ~3 ^ tmp ^ z0[idx]; forward: k[i+4] from k[i],k[i+1],k[i+3]
    // inverse: k[r] from k[r+4],k[r+1],k[r+3] (same algebraic form)
    function automatic logic [15:0] key_step(input logic [15:0] k_base,
                                             input logic [15:0] k_p1,
                                             input logic [15:0] k_p3,
                                             input logic [4:0]  idx);
        logic [15:0] tmp;
        tmp = ror16(k_p3, 4'd3) ^ k_p1;
        tmp = tmp ^ ror16(tmp, 4'd1);
        return k_base ^ C_MASK ^ tmp ^ {15'd0, z0_bit(idx)};
    endfunction

    function automatic bit mixed_size_ok(input int m);
        return (m == 1) || (m == 2) || (m == 4) || (m == 8) || (m == 16) || (m == 32);
    endfunction

endpackage
`default_nettype wire

// File: rtl/simon_inv_step.sv
`default_nettype none
// ============================================================================
//  Module      : simon_inv_step
//  Description : One combinational SIMON32/64 inverse iteration: recovers
//                round key k[r] from the window k[r+1..r+4] and undoes round r.
//  Revision    : 1.0 - initial release
// ============================================================================
module simon_inv_step
    import simon_pkg::*;
(
    input  logic [63:0] win,     // k[r+1] in [15:0] ... k[r+4] in [63:48]
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    input  logic [4:0]  r,
    output logic [15:0] k_new,   // k[r]
    output logic [15:0] x_out,
    output logic [15:0] y_out
);

    assign k_new = key_step(win[63:48], win[15:0], win[47:32], r);
    assign x_out = y_in;
    assign y_out = x_in ^ simon_f(y_in) ^ k_new;

endmodule
`default_nettype wire

// File: rtl/simon_mixed_decipher_core.sv
`default_nettype none
// ============================================================================
//  Module      : simon_mixed_decipher_core
//  Description : SIMON32/64 decryption core. Runs the forward key schedule
//                to reach k32..k35, then walks it backwards while undoing the
//                32 rounds, MIXED_SIZE steps per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module simon_mixed_decipher_core
    import simon_pkg::*;
#(
    parameter int MIXED_SIZE = 8
)
(
    input  logic        clk,
    input  logic        rst,          // asynchronous, active low
    input  logic        load,
    input  logic [63:0] key,
    input  logic [31:0] ciphertext,
    output logic [31:0] plaintext,
    output logic        busy,
    output logic        done
);

    localparam int         N      = 32 / MIXED_SIZE;
    localparam logic [4:0] C_LAST = 5'(N - 1);

    if (!mixed_size_ok(MIXED_SIZE)) begin : g_bad_size
        $error("simon_mixed_decipher_core: MIXED_SIZE must be 1, 2, 4, 8, 16 or 32");
    end

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_kw;           // key window, lowest index in [15:0]
    logic [15:0] r_xr;
    logic [15:0] r_yr;

    logic [4:0]  w_base;
    logic [63:0] w_exp_win;
    logic [63:0] w_dec_win;
    logic [15:0] w_dec_x;
    logic [15:0] w_dec_y;

    assign w_base = 5'(r_cnt * MIXED_SIZE);

    // Forward key schedule: MIXED_SIZE steps slide the window up the key sequence
    always_comb begin
        w_exp_win = r_kw;
        for (int j = 0; j < MIXED_SIZE; j++) begin
            w_exp_win = {key_step(w_exp_win[15:0], w_exp_win[31:16], w_exp_win[63:48],
                                  w_base + 5'(j)),
                         w_exp_win[63:16]};
        end
    end

    // Inverse rounds chained MIXED_SIZE deep; round index counts down from 31
    for (genvar j = 0; j < MIXED_SIZE; j++) begin : g_inv
        logic [63:0] win;
        logic [15:0] xi;
        logic [15:0] yi;
        logic [15:0] kn;
        logic [15:0] xo;
        logic [15:0] yo;
        logic [4:0]  ri;

        if (j == 0) begin : g_first
            assign win = r_kw;
            assign xi  = r_xr;
            assign yi  = r_yr;
        end else begin : g_next
            assign win = {g_inv[j-1].win[47:0], g_inv[j-1].kn};
            assign xi  = g_inv[j-1].xo;
            assign yi  = g_inv[j-1].yo;
        end

        assign ri = 5'd31 - w_base - 5'(j);

        simon_inv_step u_step (
            .win   (win),
            .x_in  (xi),
            .y_in  (yi),
            .r     (ri),
            .k_new (kn),
            .x_out (xo),
            .y_out (yo)
        );
    end

    assign w_dec_win = {g_inv[MIXED_SIZE-1].win[47:0], g_inv[MIXED_SIZE-1].kn};
    assign w_dec_x   = g_inv[MIXED_SIZE-1].xo;
    assign w_dec_y   = g_inv[MIXED_SIZE-1].yo;

    // Controller: load always restarts; final DECRYPT cycle publishes the result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= 5'd0;
            r_kw      <= 64'd0;
            r_xr      <= 16'd0;
            r_yr      <= 16'd0;
            plaintext <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                r_state <= EXPAND;
                r_cnt   <= 5'd0;
                r_kw    <= key;
                r_xr    <= ciphertext[31:16];
                r_yr    <= ciphertext[15:0];
                busy    <= 1'b1;
            end else begin
                case (r_state)
                    EXPAND: begin
                        r_kw <= w_exp_win;
                        if (r_cnt == C_LAST) begin
                            r_cnt   <= 5'd0;
                            r_state <= DECRYPT;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    DECRYPT: begin
                        r_kw <= w_dec_win;
                        r_xr <= w_dec_x;
                        r_yr <= w_dec_y;
                        if (r_cnt == C_LAST) begin
                            r_cnt     <= 5'd0;
                            r_state   <= IDLE;
                            plaintext <= {w_dec_x, w_dec_y};
                            done      <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simon_mixed_decipher_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_simon_mixed_decipher_core
//  Description : Directed self-checking bench for the SIMON32/64 decipher
//                core (MIXED_SIZE = 8, latency 8 cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_simon_mixed_decipher_core;

    localparam int LAT = 8;

    logic        clk;
    logic        rst;
    logic        load;
    logic [63:0] key;
    logic [31:0] ciphertext;
    logic [31:0] plaintext;
    logic        busy;
    logic        done;

    int checks;
    int errors;

    simon_mixed_decipher_core #(.MIXED_SIZE(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .key        (key),
        .ciphertext (ciphertext),
        .plaintext  (plaintext),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encryption, written straight from the SIMON32/64 definition
    function automatic logic [15:0] m_rol(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [15:0] m_ror(input logic [15:0] v, input int n);
        return (v >> n) | (v << (16 - n));
    endfunction

    function automatic logic [31:0] model_encrypt(input logic [63:0] k64, input logic [31:0] pt);
        logic [61:0] zs;
        logic [15:0] k [0:31];
        logic [15:0] tmp;
        logic [15:0] x;
        logic [15:0] y;
        zs = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int i = 0; i < 4; i++) k[i] = k64[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            tmp  = m_ror(k[i-1], 3) ^ k[i-3];
            tmp  = tmp ^ m_ror(tmp, 1);
            k[i] = ~k[i-4] ^ tmp ^ {15'd0, zs[61-(i-4)]} ^ 16'h0003;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            tmp = x;
            x   = y ^ ((m_rol(x, 1) & m_rol(x, 8)) ^ m_rol(x, 2)) ^ k[i];
            y   = tmp;
        end
        return {x, y};
    endfunction

    task automatic start_load(input logic [63:0] k, input logic [31:0] c);
        key        = k;
        ciphertext = c;
        load       = 1'b1;
        @(posedge clk); #1;
        load       = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (plaintext !== 32'd0) begin
            errors++;
            $display("FAIL reset_plaintext: got %h expected %h", plaintext, 32'd0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
    endtask

    task automatic test_known_vector();
        start_load(64'h1918111009080100, 32'hc69be9bb);
        for (int c = 1; c <= LAT; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end else begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL kv_start: busy=%b done=%b expected busy=1 done=0", busy, done);
                end
                @(posedge clk); #1;
            end
            if (c < LAT) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL kv_running c=%0d: busy=%b done=%b expected busy=1 done=0", c, busy, done);
                end
            end else begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL kv_finish: done=%b busy=%b expected done=1 busy=0", done, busy);
                end
                checks++;
                if (plaintext !== 32'h65656877) begin
                    errors++;
                    $display("FAIL kv_plaintext: got %h expected 65656877", plaintext);
                end
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || plaintext !== 32'h65656877) begin
            errors++;
            $display("FAIL kv_after: done=%b plaintext=%h expected done=0 plaintext=65656877", done, plaintext);
        end
    endtask

    task automatic test_roundtrip();
        logic [63:0] keys [0:3];
        logic [31:0] pts  [0:3];
        logic [31:0] ct;
        int cyc;
        keys[0] = 64'h0123456789abcdef; pts[0] = 32'hdeadbeef;
        keys[1] = 64'hffffffffffffffff; pts[1] = 32'h00000000;
        keys[2] = 64'h0000000000000000; pts[2] = 32'hffffffff;
        keys[3] = 64'hfedcba9876543210; pts[3] = 32'h13579bdf;
        for (int v = 0; v < 4; v++) begin
            ct = model_encrypt(keys[v], pts[v]);
            start_load(keys[v], ct);
            // inputs may change freely while busy
            key        = ~keys[v];
            ciphertext = ~ct;
            wait_done(cyc);
            checks++;
            if (cyc !== LAT) begin
                errors++;
                $display("FAIL rt_latency v=%0d: got %0d cycles expected %0d", v, cyc, LAT);
            end
            checks++;
            if (plaintext !== pts[v]) begin
                errors++;
                $display("FAIL rt_plaintext v=%0d: got %h expected %h", v, plaintext, pts[v]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reload();
        int cyc;
        start_load(64'h0123456789abcdef, 32'h12345678);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reload_first: done=%b busy=%b expected done=0 busy=1", done, busy);
        end
        start_load(64'h1918111009080100, 32'hc69be9bb);
        wait_done(cyc);
        checks++;
        if (cyc !== LAT) begin
            errors++;
            $display("FAIL reload_latency: got %0d cycles expected %0d", cyc, LAT);
        end
        checks++;
        if (plaintext !== 32'h65656877) begin
            errors++;
            $display("FAIL reload_plaintext: got %h expected 65656877", plaintext);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_load(64'h0123456789abcdef, model_encrypt(64'h0123456789abcdef, 32'hdeadbeef));
        for (int c = 1; c < LAT; c++) begin
            @(posedge clk); #1;
        end
        // load on the edge that would finish the first run
        key        = 64'h1918111009080100;
        ciphertext = 32'hc69be9bb;
        load       = 1'b1;
        @(posedge clk); #1;
        load       = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_discard: done=%b busy=%b expected done=0 busy=1", done, busy);
        end
        checks++;
        if (plaintext === 32'hdeadbeef) begin
            errors++;
            $display("FAIL b2b_no_update: got %h expected not deadbeef", plaintext);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== LAT || plaintext !== 32'h65656877) begin
            errors++;
            $display("FAIL b2b_second: cycles=%0d plaintext=%h expected %0d and 65656877", cyc, plaintext, LAT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        int cyc;
        start_load(64'h1918111009080100, 32'hc69be9bb);
        for (int c = 1; c < 6; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || plaintext !== 32'd0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b plaintext=%h expected 0 0 00000000", busy, done, plaintext);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_idle: busy=%b done=%b expected 0 0", busy, done);
        end
        start_load(64'h1918111009080100, 32'hc69be9bb);
        wait_done(cyc);
        checks++;
        if (cyc !== LAT || plaintext !== 32'h65656877) begin
            errors++;
            $display("FAIL midrun_fresh: cycles=%0d plaintext=%h expected %0d and 65656877", cyc, plaintext, LAT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_held();
        int cyc;
        bit seen_done;
        seen_done  = 1'b0;
        key        = 64'h1918111009080100;
        ciphertext = 32'hc69be9bb;
        load       = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done = 1'b1;
        end
        load = 1'b0;
        checks++;
        if (seen_done || busy !== 1'b1) begin
            errors++;
            $display("FAIL held_no_done: seen_done=%b busy=%b expected 0 1", seen_done, busy);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== LAT || plaintext !== 32'h65656877) begin
            errors++;
            $display("FAIL held_release: cycles=%0d plaintext=%h expected %0d and 65656877", cyc, plaintext, LAT);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        load       = 1'b0;
        key        = 64'd0;
        ciphertext = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        test_known_vector();
        test_roundtrip();
        test_reload();
        test_back_to_back();
        test_reset_midrun();
        test_load_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
